orb_frame_sequencer: RTL

ORB_FRAME_SEQUENCER -- requirements
Module: orb_frame_sequencer

---
 rtl/orb_frame_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/orb_frame_sequencer.sv
// Frame sequencer wrapping a fixed-latency ORB core: AXI-Stream in -> core -> output FIFO -> AXI-Stream out.
// Optional output stall counter enabled by defining ORB_SEQ_STALL_CNT_EN. CORE_LAT must be at least 2.
module orb_frame_sequencer #(
  parameter int H_ACTIVE   = 720,
  parameter int V_ACTIVE   = 480,
  parameter int CORE_LAT   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        axi_Mclk,
  input  logic        axi_reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] core_data,
  output logic        core_en,
  input  logic [31:0] core_result,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [3:0]  m_axis_tkeep,
  output logic [9:0]  hs_cnt,
  output logic [9:0]  vs_cnt,
  output logic        busy,
  output logic        frame_done_intr,
  output logic [1:0]  seq_state,
  output logic [31:0] stall_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(FIFO_DEPTH + CORE_LAT + 2) + 1;
  localparam logic [18:0] LAST_BEAT = 19'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t                r_state, w_next;
  logic [31:0]           r_core_data;
  logic                  r_core_en;
  logic [CORE_LAT-1:0]   r_vld_pipe;
  logic [31:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_fcnt;
  logic [9:0]            r_hs, r_vs;
  logic [18:0]           r_obeat;
  logic [IW-1:0]         w_inflight;
  logic                  w_s_tready, w_s_acc, w_push, w_pop, w_m_tvalid, w_last_in, w_start_go;

  // In-flight covers every beat already committed to a FIFO slot: the core_en
  // register, the core latency pipe and the FIFO itself.
  always_comb begin
    w_inflight = IW'(r_fcnt) + IW'(r_core_en);
    for (int i = 0; i < CORE_LAT; i++) w_inflight = w_inflight + IW'(r_vld_pipe[i]);
  end

  assign w_s_tready = (r_state == S_RUN) && (w_inflight < IW'(FIFO_DEPTH));
  assign w_s_acc    = s_axis_tvalid && w_s_tready;
  assign w_push     = r_vld_pipe[CORE_LAT-1];
  assign w_m_tvalid = (r_fcnt != '0);
  assign w_pop      = w_m_tvalid && m_axis_tready;
  assign w_last_in  = (r_hs == 10'(H_ACTIVE - 1)) && (r_vs == 10'(V_ACTIVE - 1));
  assign w_start_go = (r_state == S_IDLE) && start && !abort;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_s_acc && w_last_in) w_next = S_DRAIN;
      S_DRAIN: if (w_inflight == '0) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge axi_Mclk) begin
    if (!axi_reset_n) r_state <= S_IDLE;
    else              r_state <= w_next;
  end

  always_ff @(posedge axi_Mclk) begin
    if (!axi_reset_n || abort) begin
      r_core_data <= '0;
      r_core_en   <= 1'b0;
      r_vld_pipe  <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fcnt      <= '0;
      r_hs        <= '0;
      r_vs        <= '0;
      r_obeat     <= '0;
    end else begin
      r_core_en  <= w_s_acc;
      if (w_s_acc) r_core_data <= s_axis_tdata;
      r_vld_pipe <= {r_vld_pipe[CORE_LAT-2:0], r_core_en};
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_pop);
      if (w_start_go) begin
        r_hs    <= '0;
        r_vs    <= '0;
        r_obeat <= '0;
      end else begin
        if (w_s_acc) begin
          if (r_hs == 10'(H_ACTIVE - 1)) begin
            r_hs <= '0;
            r_vs <= (r_vs == 10'(V_ACTIVE - 1)) ? '0 : r_vs + 1'b1;
          end else begin
            r_hs <= r_hs + 1'b1;
          end
        end
        if (w_pop) r_obeat <= (r_obeat == LAST_BEAT) ? '0 : r_obeat + 1'b1;
      end
    end
  end

  // Storage needs no reset: the read path is gated by the occupancy count.
  always_ff @(posedge axi_Mclk) begin
    if (w_push) r_mem[r_wptr] <= core_result;
  end

`ifdef ORB_SEQ_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge axi_Mclk) begin
    if (!axi_reset_n || abort)                                   r_stall <= '0;
    else if (w_start_go)                                         r_stall <= '0;
    else if (r_state != S_IDLE && w_m_tvalid && !m_axis_tready &&
             r_stall != 32'hFFFF_FFFF)                           r_stall <= r_stall + 1'b1;
  end
  assign stall_cnt = r_stall;
`else
  assign stall_cnt = '0;
`endif

  assign s_axis_tready   = w_s_tready;
  assign core_data       = r_core_data;
  assign core_en         = r_core_en;
  assign m_axis_tvalid   = w_m_tvalid;
  assign m_axis_tdata    = w_m_tvalid ? r_mem[r_rptr] : '0;
  assign m_axis_tlast    = w_m_tvalid && (r_obeat == LAST_BEAT);
  assign m_axis_tkeep    = {4{w_m_tvalid}};
  assign hs_cnt          = r_hs;
  assign vs_cnt          = r_vs;
  assign busy            = (r_state != S_IDLE);
  assign frame_done_intr = (r_state == S_DONE);
  assign seq_state       = r_state;

endmodule
